rtc_bcd_core: RTL and testbench
===============================

Name: rtc_bcd_core

Overview:
Parametrised BCD time-of-day core, HH:MM:SS, 24-hour. It is the successor to the board-level clock counter. It supplies a configurable prescaler, a per-field set interface (inc/dec/load) with defined priorities and no cross-field carry, a day-rollover pulse and an optional alarm. It sits between the key_filter outputs / mode FSM and the hex8 display driver; the display packs Time_BCD as it needs.

Parameters:
CLK_DIV, 50_000_000, Clk cycles per second; must be ≥2.
ALARM_SECS, 60, duration of Alarm_Ring in seconds; must be ≥1.

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
Run  input  1  1 = prescaler and time advance; 0 = frozen (edits still accepted)
Sel  input  2  edit field: 0 sec, 1 min, 2 hour, 3 none
Inc  input  1  one-cycle pulse, +1 on selected field
Dec  input  1  one-cycle pulse, -1 on selected field
Load  input  1  one-cycle pulse, load Load_Time
Load_Time  input  24  {H10,H1,M10,M1,S10,S1}, 4-bit BCD each
Alarm_Wr  input  1  pulse, latch Alarm_Time and Alarm_On
Alarm_Time  input  16  {H10,H1,M10,M1} BCD
Alarm_On  input  1  alarm arm value written by Alarm_Wr
Alarm_Stop  input  1  pulse, silence ringing alarm
Time_BCD  output  24  current time, same packing as Load_Time
Sec_Tick  output  1  one-cycle pulse per elapsed second
Day_Carry  output  1  one-cycle pulse on 23:59:59 -> 00:00:00
Load_Err  output  1  one-cycle pulse, Load rejected
Alarm_Ring  output  1  alarm active

Behaviour:
- Reset (async): time 00:00:00, prescaler 0, all pulse outputs 0, alarm 00:00 disarmed, Alarm_Ring 0. Deassertion is synchronised externally.
- Prescaler: counts 0..CLK_DIV-1 while Run=1; holds while Run=0.
  - Sec_Tick=1 in the cycle the count equals CLK_DIV-1 with Run=1.
  - Time advances on that same edge; registered outputs show the new value the next cycle.
- Auto advance cascade: S1 9->0 carries into S10; S10 5->0 into M1; M1 9->0 into M10; M10 5->0 into hours.
  - Hours run 00..23; 23->00 with M=59, S=59 asserts Day_Carry in the cycle after the tick, alongside the new time.
- Priority per cycle: Load > (Inc xor Dec) > auto tick. A tick coinciding with Load or an edit is dropped for that second; the prescaler still wraps.
- Load: every nibble must be valid BCD, H ≤ 23, M ≤ 59, S ≤ 59.
  - Valid: time replaced and prescaler cleared to 0.
  - Invalid: time unchanged; Load_Err pulses 1 cycle later.
- Edit: Inc or Dec with Sel 0/1/2 changes only that field, modulo 60/60/24, wrapping inside the field.
  - No carry or borrow to other fields; Day_Carry is never asserted by an edit.
  - Examples: sec 59+1 -> 00; hour 00-1 -> 23; hour 19+1 -> 20, with BCD wrap of the units digit.
  - An edit on the seconds field also clears the prescaler.
  - Inc and Dec together, or Sel=3: no change.
- Edits and Load are accepted regardless of Run.
- All outputs are registered.

Optional Feature:
- Macro RTC_ALARM_EN.
- Defined:
  - Alarm registers are written on Alarm_Wr; an invalid Alarm_Time (H > 23 or M > 59) is ignored and raises Load_Err.
  - When armed and the auto tick advances time to HH:MM:00 equal to the alarm, Alarm_Ring rises with the new time.
  - Alarm_Ring stays high for ALARM_SECS Sec_Ticks, or until Alarm_Stop, or until Alarm_Wr with Alarm_On=0; it drops the following cycle.
  - Loading or editing into a match does not trigger the alarm.
  - A new match while ringing restarts the duration count.
- Undefined: no alarm registers; Alarm_Ring tied 0; Alarm_Wr, Alarm_Time, Alarm_On and Alarm_Stop ignored.

Test Plan:
1. CLK_DIV=4, Run=1 from reset -> Sec_Tick every 4 cycles; after 3 ticks Time_BCD=00:00:03.
2. Load 23:59:58, 2 ticks -> 23:59:59, then 00:00:00 with a single Day_Carry pulse; Load 24:00:00 -> Load_Err pulse, time unchanged.
3. Time 12:59:59, Sel=1, Inc -> 12:00:59 (no hour carry); Sel=2, Dec at 00 -> 23; Inc and Dec in the same cycle -> no change.
4. Load coinciding with Sec_Tick -> loaded value shown, no increment that second, next tick at CLK_DIV cycles; Run=0 for 10 cycles -> time and prescaler frozen, Inc still applied.
5. RTC_ALARM_EN, ALARM_SECS=2: alarm 07:30 armed, Load 07:29:59, tick -> 07:30:00 with Alarm_Ring=1, low after 2 more ticks; repeat with Alarm_Stop mid-ring -> low next cycle.
6. Assert Reset_n low mid-count and mid-ring -> outputs clear immediately without a clock edge, time 00:00:00.

Source files
------------

// File: rtl/rtc_bcd_core_if.sv
// rtl/rtc_bcd_core_if.sv - Control and status bundle between the mode logic and rtc_bcd_core.
interface rtc_bcd_core_if;
  logic        run_i;
  logic [1:0]  sel_i;
  logic        inc_i;
  logic        dec_i;
  logic        load_i;
  logic [23:0] load_time_i;
  logic        alarm_wr_i;
  logic [15:0] alarm_time_i;
  logic        alarm_on_i;
  logic        alarm_stop_i;
  logic [23:0] time_bcd_o;
  logic        sec_tick_o;
  logic        day_carry_o;
  logic        load_err_o;
  logic        alarm_ring_o;

  modport master (
    output run_i, sel_i, inc_i, dec_i, load_i, load_time_i,
    output alarm_wr_i, alarm_time_i, alarm_on_i, alarm_stop_i,
    input  time_bcd_o, sec_tick_o, day_carry_o, load_err_o, alarm_ring_o
  );

  modport slave (
    input  run_i, sel_i, inc_i, dec_i, load_i, load_time_i,
    input  alarm_wr_i, alarm_time_i, alarm_on_i, alarm_stop_i,
    output time_bcd_o, sec_tick_o, day_carry_o, load_err_o, alarm_ring_o
  );
endinterface

// File: rtl/rtc_bcd_core.sv
// rtl/rtc_bcd_core.sv - BCD HH:MM:SS time-of-day core with prescaler and per-field editing.
// The alarm is compiled in only when RTC_ALARM_EN is defined.
module rtc_bcd_core #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned ALARM_SECS = 60
) (
  input logic           clk_i,
  input logic           rst_ni,
  rtc_bcd_core_if.slave bus
);
  localparam int unsigned   PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)              r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00)            r = max;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Byte compares against BCD limits are only meaningful once every nibble is a digit.
  function automatic logic time_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok && (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_q, time_d;
  logic          sec_tick_q, day_carry_q, day_carry_d, load_err_q, load_err_d;
  logic          tick, edit, load_ok, auto_tick, alarm_err;
  logic          s_wrap, m_wrap, h_wrap;

  always_comb begin
    tick      = bus.run_i && (presc_q == PRESC_MAX);
    load_ok   = time_ok(bus.load_time_i);
    edit      = (bus.inc_i ^ bus.dec_i) && (bus.sel_i != 2'd3);
    auto_tick = tick && !bus.load_i && !edit;
    s_wrap    = (time_q[7:0]   == 8'h59);
    m_wrap    = (time_q[15:8]  == 8'h59);
    h_wrap    = (time_q[23:16] == 8'h23);

    presc_d = presc_q;
    if (bus.run_i) presc_d = tick ? '0 : presc_q + PW'(1);
    if ((bus.load_i && load_ok) || (!bus.load_i && edit && bus.sel_i == 2'd0)) presc_d = '0;

    time_d = time_q;
    if (bus.load_i) begin
      if (load_ok) time_d = bus.load_time_i;
    end else if (edit) begin
      // Edits wrap inside the selected field only; neighbours never see a carry.
      case (bus.sel_i)
        2'd0:    time_d[7:0]   = bus.inc_i ? bcd_inc(time_q[7:0], 8'h59)   : bcd_dec(time_q[7:0], 8'h59);
        2'd1:    time_d[15:8]  = bus.inc_i ? bcd_inc(time_q[15:8], 8'h59)  : bcd_dec(time_q[15:8], 8'h59);
        default: time_d[23:16] = bus.inc_i ? bcd_inc(time_q[23:16], 8'h23) : bcd_dec(time_q[23:16], 8'h23);
      endcase
    end else if (tick) begin
      time_d[7:0] = bcd_inc(time_q[7:0], 8'h59);
      if (s_wrap)           time_d[15:8]  = bcd_inc(time_q[15:8], 8'h59);
      if (s_wrap && m_wrap) time_d[23:16] = bcd_inc(time_q[23:16], 8'h23);
    end

    day_carry_d = auto_tick && s_wrap && m_wrap && h_wrap;
    load_err_d  = (bus.load_i && !load_ok) || alarm_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      time_q      <= '0;
      sec_tick_q  <= 1'b0;
      day_carry_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      sec_tick_q  <= tick;
      day_carry_q <= day_carry_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.time_bcd_o  = time_q;
  assign bus.sec_tick_o  = sec_tick_q;
  assign bus.day_carry_o = day_carry_q;
  assign bus.load_err_o  = load_err_q;

`ifdef RTC_ALARM_EN
  localparam int unsigned CW = $clog2(ALARM_SECS + 1);

  logic [15:0]   alarm_q;
  logic          alarm_on_q, ring_q, ring_d, alarm_ok, ring_stop, match;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;

  always_comb begin
    alarm_ok  = time_ok({bus.alarm_time_i, 8'h00});
    alarm_err = bus.alarm_wr_i && !alarm_ok;
    ring_stop = bus.alarm_stop_i || (bus.alarm_wr_i && alarm_ok && !bus.alarm_on_i);
    match     = auto_tick && alarm_on_q && (time_d == {alarm_q, 8'h00});
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    // The ticks after the matching one count down the ring duration.
    if (ring_stop) begin
      ring_d = 1'b0;
    end else if (match) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end else if (ring_q && tick) begin
      if (ring_cnt_q == CW'(ALARM_SECS - 1)) ring_d = 1'b0;
      else ring_cnt_d = ring_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_q    <= '0;
      alarm_on_q <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      if (bus.alarm_wr_i && alarm_ok) begin
        alarm_q    <= bus.alarm_time_i;
        alarm_on_q <= bus.alarm_on_i;
      end
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign bus.alarm_ring_o = ring_q;
`else
  logic unused_alarm;
  assign unused_alarm     = ^{bus.alarm_wr_i, bus.alarm_time_i, bus.alarm_on_i, bus.alarm_stop_i};
  assign alarm_err        = 1'b0;
  assign bus.alarm_ring_o = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb/tb_rtc_bcd_core.sv - Self-checking bench for rtc_bcd_core against a seconds-of-day model.
module tb_rtc_bcd_core;
  localparam int CLK_DIV    = 4;
  localparam int ALARM_SECS = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   r_amin;

  rtc_bcd_core_if bus();

  rtc_bcd_core #(.CLK_DIV(CLK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: time held as seconds since midnight, alarm as minutes since midnight.
  int m_pre, m_secs, m_amin, m_left;
  bit m_tick, m_day, m_err, m_armed, m_ring;

  function automatic bit time_ok(input logic [23:0] t);
    for (int i = 0; i < 6; i++) if (t[i*4 +: 4] > 4'd9) return 1'b0;
    return (int'(t[23:20]) * 10 + int'(t[19:16]) < 24) &&
           (int'(t[15:12]) * 10 + int'(t[11:8]) < 60) &&
           (int'(t[7:4]) * 10 + int'(t[3:0]) < 60);
  endfunction

  function automatic int time_secs(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    automatic bit tick, lv, edit, auto_t, av, stop, match, err_n, armed_n, ring_n;
    automatic int pre_n, secs_n, h, mi, se, d, left_n, amin_n;
    if (!rst_n) begin
      m_pre <= 0; m_secs <= 0; m_tick <= 0; m_day <= 0; m_err <= 0;
      m_amin <= 0; m_armed <= 0; m_ring <= 0; m_left <= 0;
    end else begin
      tick   = bus.run_i && (m_pre == CLK_DIV - 1);
      lv     = time_ok(bus.load_time_i);
      edit   = (bus.inc_i != bus.dec_i) && (bus.sel_i != 2'd3);
      auto_t = tick && !bus.load_i && !edit;
      pre_n  = !bus.run_i ? m_pre : (tick ? 0 : m_pre + 1);
      if ((bus.load_i && lv) || (!bus.load_i && edit && bus.sel_i == 2'd0)) pre_n = 0;
      secs_n = m_secs;
      if (bus.load_i) begin
        if (lv) secs_n = time_secs(bus.load_time_i);
      end else if (edit) begin
        h = m_secs / 3600; mi = (m_secs / 60) % 60; se = m_secs % 60;
        d = bus.inc_i ? 1 : -1;
        case (bus.sel_i)
          2'd0:    se = (se + d + 60) % 60;
          2'd1:    mi = (mi + d + 60) % 60;
          default: h  = (h + d + 24) % 24;
        endcase
        secs_n = h * 3600 + mi * 60 + se;
      end else if (tick) begin
        secs_n = (m_secs + 1) % 86400;
      end
      err_n   = bus.load_i && !lv;
      armed_n = m_armed; amin_n = m_amin; ring_n = m_ring; left_n = m_left;
`ifdef RTC_ALARM_EN
      av = time_ok({bus.alarm_time_i, 8'h00});
      if (bus.alarm_wr_i) begin
        if (av) begin
          amin_n  = time_secs({bus.alarm_time_i, 8'h00}) / 60;
          armed_n = bus.alarm_on_i;
        end else begin
          err_n = 1'b1;
        end
      end
      stop  = bus.alarm_stop_i || (bus.alarm_wr_i && av && !bus.alarm_on_i);
      match = auto_t && m_armed && (secs_n == m_amin * 60);
      if (stop) ring_n = 1'b0;
      else if (match) begin ring_n = 1'b1; left_n = ALARM_SECS; end
      else if (m_ring && tick) begin
        left_n = m_left - 1;
        if (left_n == 0) ring_n = 1'b0;
      end
`endif
      m_pre   <= pre_n;
      m_secs  <= secs_n;
      m_tick  <= tick;
      m_day   <= auto_t && (m_secs == 86399);
      m_err   <= err_n;
      m_armed <= armed_n;
      m_amin  <= amin_n;
      m_ring  <= ring_n;
      m_left  <= left_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("time_bcd", 32'(bus.time_bcd_o), 32'(to_bcd(m_secs)));
      chk("sec_tick", 32'(bus.sec_tick_o), 32'(m_tick));
      chk("day_carry", 32'(bus.day_carry_o), 32'(m_day));
      chk("load_err", 32'(bus.load_err_o), 32'(m_err));
      chk("alarm_ring", 32'(bus.alarm_ring_o), 32'(m_ring));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [23:0] t);
    @(negedge clk); bus.load_time_i = t; bus.load_i = 1'b1;
    @(negedge clk); bus.load_i = 1'b0;
  endtask

  task automatic pulse_edit(input logic [1:0] s, input logic i, input logic d);
    @(negedge clk); bus.sel_i = s; bus.inc_i = i; bus.dec_i = d;
    @(negedge clk); bus.inc_i = 1'b0; bus.dec_i = 1'b0; bus.sel_i = 2'd3;
  endtask

  task automatic pulse_alarm(input logic [15:0] t, input logic on);
    @(negedge clk); bus.alarm_time_i = t; bus.alarm_on_i = on; bus.alarm_wr_i = 1'b1;
    @(negedge clk); bus.alarm_wr_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [23:0] tmp;
    int          waited;
    checks = 0; failures = 0; r_amin = 0;
    rst_n = 1'b0;
    bus.run_i = 1'b0; bus.sel_i = 2'd3; bus.inc_i = 1'b0; bus.dec_i = 1'b0;
    bus.load_i = 1'b0; bus.load_time_i = '0; bus.alarm_wr_i = 1'b0;
    bus.alarm_time_i = '0; bus.alarm_on_i = 1'b0; bus.alarm_stop_i = 1'b0;
    cyc(3);
    chk("reset_time", 32'(bus.time_bcd_o), 32'h0);
    chk("reset_tick", 32'(bus.sec_tick_o), 32'h0);
    chk("reset_ring", 32'(bus.alarm_ring_o), 32'h0);

    @(negedge clk); rst_n = 1'b1; bus.run_i = 1'b1;
    cyc(12);
    chk("three_ticks", 32'(bus.time_bcd_o), 32'h000003);

    pulse_load(24'h235958);
    cyc(4);
    chk("rollover_pre", 32'(bus.time_bcd_o), 32'h235959);
    cyc(4);
    chk("rollover_time", 32'(bus.time_bcd_o), 32'h000000);
    chk("rollover_day", 32'(bus.day_carry_o), 32'h1);
    pulse_load(24'h240000);
    chk("bad_load_err", 32'(bus.load_err_o), 32'h1);

    @(negedge clk); bus.run_i = 1'b0;
    pulse_load(24'h125959);
    pulse_edit(2'd1, 1'b1, 1'b0);
    chk("min_inc_wrap", 32'(bus.time_bcd_o), 32'h120059);
    pulse_load(24'h000000);
    pulse_edit(2'd2, 1'b0, 1'b1);
    chk("hour_dec_wrap", 32'(bus.time_bcd_o), 32'h230000);
    pulse_edit(2'd2, 1'b1, 1'b1);
    chk("inc_dec_both", 32'(bus.time_bcd_o), 32'h230000);
    pulse_edit(2'd3, 1'b1, 1'b0);
    chk("sel_none", 32'(bus.time_bcd_o), 32'h230000);
    pulse_load(24'h190000);
    pulse_edit(2'd2, 1'b1, 1'b0);
    chk("hour_19_inc", 32'(bus.time_bcd_o), 32'h200000);
    pulse_load(24'h000059);
    pulse_edit(2'd0, 1'b1, 1'b0);
    chk("sec_59_inc", 32'(bus.time_bcd_o), 32'h000000);

    @(negedge clk); bus.run_i = 1'b1;
    waited = 0;
    while (m_pre != CLK_DIV - 1 && waited < 2 * CLK_DIV) begin
      @(negedge clk); waited++;
    end
    chk("tick_align", 32'(m_pre), 32'(CLK_DIV - 1));
    bus.load_time_i = 24'h100000; bus.load_i = 1'b1;
    @(negedge clk); bus.load_i = 1'b0;
    chk("load_on_tick", 32'(bus.time_bcd_o), 32'h100000);
    cyc(3);
    chk("no_early_tick", 32'(bus.time_bcd_o), 32'h100000);
    cyc(1);
    chk("tick_after_load", 32'(bus.time_bcd_o), 32'h100001);
    bus.run_i = 1'b0;
    cyc(10);
    chk("frozen", 32'(bus.time_bcd_o), 32'h100001);
    pulse_edit(2'd0, 1'b1, 1'b0);
    chk("edit_frozen", 32'(bus.time_bcd_o), 32'h100002);

    @(negedge clk); bus.run_i = 1'b1;
    pulse_alarm(16'h0730, 1'b1);
    pulse_load(24'h072959);
    cyc(4);
    chk("alarm_time", 32'(bus.time_bcd_o), 32'h073000);
`ifdef RTC_ALARM_EN
    chk("alarm_rise", 32'(bus.alarm_ring_o), 32'h1);
    cyc(4);
    chk("alarm_hold", 32'(bus.alarm_ring_o), 32'h1);
    cyc(4);
    chk("alarm_expire", 32'(bus.alarm_ring_o), 32'h0);
`endif
    pulse_load(24'h072959);
    cyc(4);
    @(negedge clk); bus.alarm_stop_i = 1'b1;
    @(negedge clk); bus.alarm_stop_i = 1'b0;
    chk("alarm_stopped", 32'(bus.alarm_ring_o), 32'h0);
`ifdef RTC_ALARM_EN
    pulse_alarm(16'h2400, 1'b1);
    chk("alarm_bad_err", 32'(bus.load_err_o), 32'h1);
`endif

    pulse_load(24'h072959);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_time", 32'(bus.time_bcd_o), 32'h0);
    chk("async_rst_ring", 32'(bus.alarm_ring_o), 32'h0);
    chk("async_rst_tick", 32'(bus.sec_tick_o), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.run_i  = ($urandom % 8) != 0;
      bus.sel_i  = 2'($urandom % 4);
      bus.inc_i  = ($urandom % 16) == 0;
      bus.dec_i  = ($urandom % 16) == 0;
      bus.load_i = ($urandom % 30) == 0;
      case ($urandom % 4)
        0:       bus.load_time_i = 24'($urandom);
        1:       bus.load_time_i = to_bcd(86399 - int'($urandom % 3));
        default: bus.load_time_i = to_bcd((r_amin * 60 + 86400 - 1 - int'($urandom % 3)) % 86400);
      endcase
      bus.alarm_wr_i = ($urandom % 150) == 0;
      if (bus.alarm_wr_i) begin
        r_amin = int'($urandom % 1440);
        tmp = to_bcd(r_amin * 60);
        bus.alarm_time_i = (($urandom % 4) == 0) ? 16'($urandom) : tmp[23:8];
        bus.alarm_on_i = ($urandom % 4) != 0;
      end
      bus.alarm_stop_i = ($urandom % 80) == 0;
    end
    @(negedge clk);
    bus.inc_i = 1'b0; bus.dec_i = 1'b0; bus.load_i = 1'b0;
    bus.alarm_wr_i = 1'b0; bus.alarm_stop_i = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
